// File: rtl/rob_multi_commit_pkg.sv
// Shared definitions for the multi-commit reorder buffer: register-name bus,
// jump/store encodings and the per-entry flags the commit selector inspects.
package rob_multi_commit_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic JUMP     = 1'b1;
    localparam logic NOT_JUMP = 1'b0;
    localparam logic STORE    = 1'b1;

    typedef logic [REG_W-1:0] name_t;

    typedef struct packed {
        logic valid;
        logic done;
        logic store;
        logic mispred;
    } entry_flags_t;

endpackage

// File: rtl/rob_multi_commit_if.sv
// Dispatch, writeback, store-commit and retirement signals of the reorder buffer.
// The ROB is the slave; the surrounding core (or a bench) is the master.
interface rob_multi_commit_if #(
    parameter int unsigned NICK_W   = 5,
    parameter int unsigned COMMIT_W = 2,
    parameter int unsigned DATA_W   = 32
);
    import rob_multi_commit_pkg::*;

    logic                       alloc_en;
    name_t                      alloc_regnm;
    logic                       alloc_store;
    logic                       alloc_pd;
    logic [NICK_W-1:0]          alloc_nick;
    logic                       full;

    logic                       ex_en;
    logic [NICK_W-1:0]          ex_nick;
    logic [DATA_W-1:0]          ex_dt;
    logic                       ex_ac;
    logic [DATA_W-1:0]          ex_j_pc;

    logic                       slb_en;
    logic [NICK_W-1:0]          slb_nick;
    logic [DATA_W-1:0]          slb_dt;

    logic                       store_en;
    logic [NICK_W-1:0]          store_nick;
    logic                       store_ack;

    logic [COMMIT_W-1:0]        rf_en;
    logic [REG_W*COMMIT_W-1:0]  rf_regnm;
    logic [DATA_W*COMMIT_W-1:0] rf_dt;
    logic [NICK_W*COMMIT_W-1:0] rf_nick;
    logic                       clr;
    logic [DATA_W-1:0]          j_pc;

    modport master (
        output alloc_en, alloc_regnm, alloc_store, alloc_pd,
        output ex_en, ex_nick, ex_dt, ex_ac, ex_j_pc,
        output slb_en, slb_nick, slb_dt, store_ack,
        input  alloc_nick, full, store_en, store_nick,
        input  rf_en, rf_regnm, rf_dt, rf_nick, clr, j_pc
    );

    modport slave (
        input  alloc_en, alloc_regnm, alloc_store, alloc_pd,
        input  ex_en, ex_nick, ex_dt, ex_ac, ex_j_pc,
        input  slb_en, slb_nick, slb_dt, store_ack,
        output alloc_nick, full, store_en, store_nick,
        output rf_en, rf_regnm, rf_dt, rf_nick, clr, j_pc
    );

endinterface

// File: rtl/rob_commit_sel.sv
// Combinational retire decision for the head and head+1 entries: plain retire,
// mispredict flush, and store issue/free through the store handshake.
module rob_commit_sel
    import rob_multi_commit_pkg::*;
#(
    parameter int unsigned COMMIT_W = 2
) (
    input  entry_flags_t head,
    input  entry_flags_t head1,
    input  logic         store_en,
    input  logic         store_ack,
    output logic [1:0]   ret,
    output logic         mispred,
    output logic         store_issue,
    output logic         store_free
);

    always_comb begin
        ret         = '0;
        mispred     = 1'b0;
        store_issue = 1'b0;
        store_free  = 1'b0;
        if (head.valid && head.done) begin
            if (head.store) begin
                if (store_en && store_ack) begin
                    store_free = 1'b1;
                end else if (!store_en) begin
                    store_issue = 1'b1;
                end
            end else begin
                ret[0]  = 1'b1;
                mispred = head.mispred;
                // Second slot only rides behind a clean plain retirement.
                if (COMMIT_W > 1 && !head.mispred && head1.valid && head1.done &&
                    !head1.store && !head1.mispred) begin
                    ret[1] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order nick allocation, EX/SLB writeback, up to COMMIT_W
// in-order retirements per cycle, store commit handshake and mispredict flush.
module rob_multi_commit
    import rob_multi_commit_pkg::*;
#(
    parameter int unsigned DEPTH    = 31,
    parameter int unsigned NICK_W   = 5,
    parameter int unsigned COMMIT_W = 2,
    parameter int unsigned DATA_W   = 32
) (
    input logic               clk,
    input logic               rst,
    input logic               rdy,
    rob_multi_commit_if.slave bus
);

    localparam int unsigned SLOTS = 2 ** NICK_W;

    typedef logic [NICK_W-1:0] nick_t;
    typedef logic [NICK_W:0]   cnt_t;

    // Storage spans every nick encoding; nick 0 and nicks above DEPTH never go valid.
    logic [SLOTS-1:0]  valid_q, done_q, store_q, pd_q, ac_q;
    name_t             regnm_q [SLOTS];
    logic [DATA_W-1:0] dt_q    [SLOTS];
    logic [DATA_W-1:0] jpc_q   [SLOTS];

    nick_t head_q, tail_q, head1;
    cnt_t  count_q, count_d, n_ret;

    logic                       store_en_q, clr_q;
    nick_t                      store_nick_q;
    logic [DATA_W-1:0]          j_pc_q;
    logic [COMMIT_W-1:0]        rf_en_q, rf_en_d;
    logic [REG_W*COMMIT_W-1:0]  rf_regnm_q, rf_regnm_d;
    logic [DATA_W*COMMIT_W-1:0] rf_dt_q, rf_dt_d;
    logic [NICK_W*COMMIT_W-1:0] rf_nick_q, rf_nick_d;

    entry_flags_t f0, f1;
    logic [1:0]   ret;
    logic         mispred, store_issue, store_free;
    logic         full, alloc_fire, ex_hit, slb_hit;
    nick_t        slot_nick [2];

    function automatic nick_t nxt(input nick_t p);
        return (p == nick_t'(DEPTH)) ? nick_t'(1) : p + nick_t'(1);
    endfunction

    assign head1        = nxt(head_q);
    assign slot_nick[0] = head_q;
    assign slot_nick[1] = head1;

    assign f0 = '{valid: valid_q[head_q], done: done_q[head_q], store: store_q[head_q],
                  mispred: pd_q[head_q] != ac_q[head_q]};
    assign f1 = '{valid: valid_q[head1], done: done_q[head1], store: store_q[head1],
                  mispred: pd_q[head1] != ac_q[head1]};

    rob_commit_sel #(
        .COMMIT_W (COMMIT_W)
    ) u_sel (
        .head        (f0),
        .head1       (f1),
        .store_en    (store_en_q),
        .store_ack   (bus.store_ack),
        .ret         (ret),
        .mispred     (mispred),
        .store_issue (store_issue),
        .store_free  (store_free)
    );

    assign full       = count_q == cnt_t'(DEPTH);
    assign alloc_fire = bus.alloc_en && !full && !clr_q && !mispred;
    assign ex_hit     = bus.ex_en && valid_q[bus.ex_nick];
    assign slb_hit    = bus.slb_en && valid_q[bus.slb_nick];
    assign n_ret      = cnt_t'(ret[0]) + cnt_t'(ret[1]) + cnt_t'(store_free);
    assign count_d    = count_q + cnt_t'(alloc_fire) - n_ret;

    for (genvar s = 0; s < COMMIT_W; s++) begin : g_slot
        assign rf_en_d[s] = ret[s] && (regnm_q[slot_nick[s]] != '0);
        assign rf_regnm_d[s*REG_W +: REG_W]   = ret[s] ? regnm_q[slot_nick[s]] : '0;
        assign rf_dt_d[s*DATA_W +: DATA_W]    = ret[s] ? dt_q[slot_nick[s]] : '0;
        assign rf_nick_d[s*NICK_W +: NICK_W]  = ret[s] ? slot_nick[s] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            done_q       <= '0;
            store_q      <= '0;
            head_q       <= nick_t'(1);
            tail_q       <= nick_t'(1);
            count_q      <= '0;
            store_en_q   <= 1'b0;
            store_nick_q <= '0;
            rf_en_q      <= '0;
            rf_regnm_q   <= '0;
            rf_dt_q      <= '0;
            rf_nick_q    <= '0;
            clr_q        <= 1'b0;
            j_pc_q       <= '0;
        end else if (rdy) begin
            rf_en_q    <= rf_en_d;
            rf_regnm_q <= rf_regnm_d;
            rf_dt_q    <= rf_dt_d;
            rf_nick_q  <= rf_nick_d;
            clr_q      <= mispred;
            j_pc_q     <= mispred ? jpc_q[head_q] : '0;
            if (store_issue) begin
                store_en_q   <= 1'b1;
                store_nick_q <= head_q;
            end else if (store_free) begin
                store_en_q   <= 1'b0;
                store_nick_q <= '0;
            end
            if (mispred) begin
                valid_q <= '0;
                done_q  <= '0;
                store_q <= '0;
                head_q  <= nick_t'(1);
                tail_q  <= nick_t'(1);
                count_q <= '0;
            end else begin
                if (slb_hit) done_q[bus.slb_nick] <= 1'b1;
                if (ex_hit)  done_q[bus.ex_nick]  <= 1'b1;
                if (ret[0] || store_free) begin
                    valid_q[head_q] <= 1'b0;
                    done_q[head_q]  <= 1'b0;
                end
                if (ret[1]) begin
                    valid_q[head1] <= 1'b0;
                    done_q[head1]  <= 1'b0;
                end
                head_q <= ret[1] ? nxt(head1) : (ret[0] || store_free) ? head1 : head_q;
                if (alloc_fire) begin
                    valid_q[tail_q] <= 1'b1;
                    done_q[tail_q]  <= 1'b0;
                    store_q[tail_q] <= bus.alloc_store;
                    tail_q          <= nxt(tail_q);
                end
                count_q <= count_d;
            end
        end else begin
            rf_en_q <= '0;
            clr_q   <= 1'b0;
        end
    end

    // Payload needs no reset: it is only read behind valid/done.
    always_ff @(posedge clk) begin
        if (rdy && !rst) begin
            if (alloc_fire) begin
                regnm_q[tail_q] <= bus.alloc_regnm;
                pd_q[tail_q]    <= bus.alloc_pd;
                ac_q[tail_q]    <= bus.alloc_pd;
            end
            if (slb_hit) begin
                dt_q[bus.slb_nick] <= bus.slb_dt;
                ac_q[bus.slb_nick] <= pd_q[bus.slb_nick];
            end
            if (ex_hit) begin
                dt_q[bus.ex_nick]  <= bus.ex_dt;
                ac_q[bus.ex_nick]  <= bus.ex_ac;
                jpc_q[bus.ex_nick] <= bus.ex_j_pc;
            end
        end
    end

    assign bus.alloc_nick = tail_q;
    assign bus.full       = full;
    assign bus.store_en   = store_en_q;
    assign bus.store_nick = store_nick_q;
    assign bus.rf_en      = rf_en_q;
    assign bus.rf_regnm   = rf_regnm_q;
    assign bus.rf_dt      = rf_dt_q;
    assign bus.rf_nick    = rf_nick_q;
    assign bus.clr        = clr_q;
    assign bus.j_pc       = j_pc_q;

endmodule

// File: tb/tb_rob_multi_commit.sv
// Bench for rob_multi_commit: directed scenarios plus random traffic, all
// checked against a program-order queue model of the reorder buffer.
module tb_rob_multi_commit;
    import rob_multi_commit_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned NICK_W   = 3;
    localparam int unsigned COMMIT_W = 2;
    localparam int unsigned DATA_W   = 32;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    rob_multi_commit_if #(.NICK_W(NICK_W), .COMMIT_W(COMMIT_W), .DATA_W(DATA_W)) bus ();

    rob_multi_commit #(
        .DEPTH    (DEPTH),
        .NICK_W   (NICK_W),
        .COMMIT_W (COMMIT_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: the live entries in program order plus the expected registered outputs.
    typedef struct {
        int          nick;
        int          regnm;
        bit          store;
        bit          pd;
        bit          ac;
        bit          done;
        logic [31:0] dt;
        logic [31:0] jpc;
    } ent_t;

    ent_t        q[$];
    int          m_tail = 1;
    bit          m_st_en = 0;
    int          m_st_nick = 0;
    bit [1:0]    m_rf_en = '0;
    int          m_rf_regnm [2];
    logic [31:0] m_rf_dt [2];
    int          m_rf_nick [2];
    bit          m_clr = 0;
    logic [31:0] m_jpc = '0;

    function automatic void retire_slot(input int s);
        m_rf_en[s]    = (q[0].regnm != 0);
        m_rf_regnm[s] = q[0].regnm;
        m_rf_dt[s]    = q[0].dt;
        m_rf_nick[s]  = q[0].nick;
    endfunction

    function automatic void model_edge();
        bit was_full;
        bit clr_now;
        bit mis;
        ent_t e;
        if (rst) begin
            q.delete();
            m_tail  = 1;
            m_st_en = 0;
            m_rf_en = '0;
            m_clr   = 0;
            return;
        end
        if (!rdy) begin
            m_rf_en = '0;
            m_clr   = 0;
            return;
        end
        was_full = (q.size() == DEPTH);
        clr_now  = m_clr;
        mis      = 0;
        m_rf_en  = '0;
        m_clr    = 0;
        if (q.size() > 0 && q[0].done) begin
            if (q[0].store) begin
                if (m_st_en && bus.store_ack) begin
                    void'(q.pop_front());
                    m_st_en = 0;
                end else if (!m_st_en) begin
                    m_st_en   = 1;
                    m_st_nick = q[0].nick;
                end
            end else begin
                retire_slot(0);
                if (q[0].pd != q[0].ac) begin
                    mis   = 1;
                    m_clr = 1;
                    m_jpc = q[0].jpc;
                end else begin
                    void'(q.pop_front());
                    if (q.size() > 0 && q[0].done && !q[0].store && q[0].pd == q[0].ac) begin
                        retire_slot(1);
                        void'(q.pop_front());
                    end
                end
            end
        end
        if (mis) begin
            q.delete();
            m_tail = 1;
            return;
        end
        foreach (q[i]) begin
            if (bus.slb_en && q[i].nick == int'(bus.slb_nick)) begin
                q[i].done = 1;
                q[i].dt   = bus.slb_dt;
                q[i].ac   = q[i].pd;
            end
            if (bus.ex_en && q[i].nick == int'(bus.ex_nick)) begin
                q[i].done = 1;
                q[i].dt   = bus.ex_dt;
                q[i].ac   = bus.ex_ac;
                q[i].jpc  = bus.ex_j_pc;
            end
        end
        if (bus.alloc_en && !was_full && !clr_now) begin
            e.nick  = m_tail;
            e.regnm = int'(bus.alloc_regnm);
            e.store = bus.alloc_store;
            e.pd    = bus.alloc_pd;
            e.ac    = bus.alloc_pd;
            e.done  = 0;
            e.dt    = '0;
            e.jpc   = '0;
            q.push_back(e);
            m_tail = (m_tail == DEPTH) ? 1 : m_tail + 1;
        end
    endfunction

    function automatic bit pd_of(input int n);
        foreach (q[i]) if (q[i].nick == n) return q[i].pd;
        return 1'b0;
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("alloc_nick", 64'(bus.alloc_nick), 64'(m_tail));
        check("full", 64'(bus.full), 64'(q.size() == DEPTH));
        check("rf_en", 64'(bus.rf_en), 64'(m_rf_en));
        check("clr", 64'(bus.clr), 64'(m_clr));
        check("store_en", 64'(bus.store_en), 64'(m_st_en));
        for (int s = 0; s < COMMIT_W; s++) begin
            if (m_rf_en[s]) begin
                check("rf_regnm", 64'(bus.rf_regnm[s*REG_W +: REG_W]), 64'(m_rf_regnm[s]));
                check("rf_dt", 64'(bus.rf_dt[s*DATA_W +: DATA_W]), 64'(m_rf_dt[s]));
                check("rf_nick", 64'(bus.rf_nick[s*NICK_W +: NICK_W]), 64'(m_rf_nick[s]));
            end
        end
        if (m_clr) check("j_pc", 64'(bus.j_pc), 64'(m_jpc));
        if (m_st_en) check("store_nick", 64'(bus.store_nick), 64'(m_st_nick));
    endtask

    task automatic idle();
        rst             = 1'b0;
        rdy             = 1'b1;
        bus.alloc_en    = 1'b0;
        bus.alloc_regnm = '0;
        bus.alloc_store = 1'b0;
        bus.alloc_pd    = NOT_JUMP;
        bus.ex_en       = 1'b0;
        bus.ex_nick     = '0;
        bus.ex_dt       = '0;
        bus.ex_ac       = NOT_JUMP;
        bus.ex_j_pc     = '0;
        bus.slb_en      = 1'b0;
        bus.slb_nick    = '0;
        bus.slb_dt      = '0;
        bus.store_ack   = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        idle();
    endtask

    task automatic alloc(input logic [4:0] rg, input logic st);
        idle();
        bus.alloc_en    = 1'b1;
        bus.alloc_regnm = rg;
        bus.alloc_store = st;
        step();
    endtask

    task automatic ex_wb(input logic [NICK_W-1:0] n, input logic [31:0] dt, input logic ac,
                         input logic [31:0] jpc);
        idle();
        bus.ex_en   = 1'b1;
        bus.ex_nick = n;
        bus.ex_dt   = dt;
        bus.ex_ac   = ac;
        bus.ex_j_pc = jpc;
        step();
    endtask

    task automatic slb_wb(input logic [NICK_W-1:0] n, input logic [31:0] dt);
        idle();
        bus.slb_en   = 1'b1;
        bus.slb_nick = n;
        bus.slb_dt   = dt;
        step();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        check("rst_alloc_nick", 64'(bus.alloc_nick), 64'd1);

        // Fill to DEPTH, overflow alloc ignored, wrap after head retires
        do_reset();
        for (int i = 1; i <= 4; i++) alloc(5'(i), 1'b0);
        check("t1_full", 64'(bus.full), 64'd1);
        alloc(5'd9, 1'b0);
        ex_wb(3'd1, 32'h11, NOT_JUMP, 32'h0);
        idle();
        step();
        check("t1_rf_en", 64'(bus.rf_en), 64'd1);
        check("t1_alloc_nick", 64'(bus.alloc_nick), 64'd1);
        alloc(5'd7, 1'b0);
        check("t1_wrap_next", 64'(bus.alloc_nick), 64'd2);

        // Dual retirement
        do_reset();
        alloc(5'd5, 1'b0);
        alloc(5'd6, 1'b0);
        ex_wb(3'd2, 32'h0000_0b0b, NOT_JUMP, 32'h0);
        ex_wb(3'd1, 32'h0000_0a0a, NOT_JUMP, 32'h0);
        idle();
        step();
        check("t2_rf_en", 64'(bus.rf_en), 64'h3);
        check("t2_rf_regnm", 64'(bus.rf_regnm), 64'((6 << 5) | 5));
        check("t2_rf_nick", 64'(bus.rf_nick), 64'((2 << 3) | 1));
        check("t2_rf_dt", 64'(bus.rf_dt), 64'h0000_0b0b_0000_0a0a);

        // Mispredict flush
        do_reset();
        alloc(5'd1, 1'b0);
        alloc(5'd2, 1'b0);
        alloc(5'd3, 1'b0);
        ex_wb(3'd2, 32'h22, NOT_JUMP, 32'h0);
        ex_wb(3'd3, 32'h33, NOT_JUMP, 32'h0);
        ex_wb(3'd1, 32'h44, JUMP, 32'h100);
        idle();
        step();
        check("t3_clr", 64'(bus.clr), 64'd1);
        check("t3_j_pc", 64'(bus.j_pc), 64'h100);
        check("t3_rf_en", 64'(bus.rf_en), 64'd1);
        step();
        check("t3_clr_off", 64'(bus.clr), 64'd0);
        check("t3_alloc_nick", 64'(bus.alloc_nick), 64'd1);

        // Store handshake
        do_reset();
        alloc(5'd0, STORE);
        alloc(5'd7, 1'b0);
        slb_wb(3'd1, 32'h0);
        ex_wb(3'd2, 32'h77, NOT_JUMP, 32'h0);
        check("t4_store_en", 64'(bus.store_en), 64'd1);
        check("t4_store_nick", 64'(bus.store_nick), 64'd1);
        idle();
        repeat (3) step();
        check("t4_store_hold", 64'(bus.store_en), 64'd1);
        bus.store_ack = 1'b1;
        step();
        check("t4_store_drop", 64'(bus.store_en), 64'd0);
        check("t4_no_ret", 64'(bus.rf_en), 64'd0);
        idle();
        step();
        check("t4_after_ret", 64'(bus.rf_en), 64'd1);

        // rdy low freezes retirement
        do_reset();
        alloc(5'd9, 1'b0);
        ex_wb(3'd1, 32'h99, NOT_JUMP, 32'h0);
        idle();
        rdy = 1'b0;
        step();
        step();
        check("t5_frozen", 64'(bus.rf_en), 64'd0);
        rdy = 1'b1;
        step();
        check("t5_resume", 64'(bus.rf_en), 64'd1);

        // Reset during an outstanding store
        do_reset();
        alloc(5'd0, STORE);
        alloc(5'd3, 1'b0);
        alloc(5'd4, 1'b0);
        slb_wb(3'd1, 32'h0);
        idle();
        step();
        check("t6_store_en", 64'(bus.store_en), 64'd1);
        rst = 1'b1;
        step();
        check("t6_rst_store", 64'(bus.store_en), 64'd0);
        check("t6_rst_nick", 64'(bus.alloc_nick), 64'd1);

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 199) == 0);
            rdy             = ($urandom_range(0, 7) != 0);
            bus.alloc_en    = 1'($urandom_range(0, 1));
            bus.alloc_regnm = 5'($urandom);
            bus.alloc_store = ($urandom_range(0, 3) == 0);
            bus.alloc_pd    = 1'($urandom_range(0, 1));
            bus.ex_en       = 1'($urandom_range(0, 1));
            bus.ex_nick     = NICK_W'($urandom_range(0, 7));
            bus.ex_dt       = $urandom;
            bus.ex_ac       = pd_of(int'(bus.ex_nick)) ^ ($urandom_range(0, 11) == 0);
            bus.ex_j_pc     = $urandom;
            bus.slb_en      = 1'($urandom_range(0, 1));
            bus.slb_nick    = NICK_W'($urandom_range(0, 7));
            bus.slb_dt      = $urandom;
            bus.store_ack   = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
Parameterised reorder buffer for the out-of-order RISC-V core. It sits between decode/dispatch and the regfile/store-load buffer. It allocates nicks (tags) in program order, collects EX/SLB results, and retires up to COMMIT_W entries per cycle in order. It adds three things to the single-commit 32-entry ROB: configurable depth, multi-commit, and an explicit store commit handshake. It owns misprediction flush generation.

Parameters:
DEPTH, 31, number of entries; nicks are 1..DEPTH and nick 0 means "no nick"; DEPTH ≤ 2^NICK_W−1.
NICK_W, 5, nick width.
COMMIT_W, 2, maximum retirements per cycle; legal values are 1 and 2.
DATA_W, 32, result and address width.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rdy  in  1  global enable; when low, all state is frozen
alloc_en  in  1  allocate one entry this cycle
alloc_regnm  in  5  destination architectural register (0 = none)
alloc_store  in  1  entry is SB/SH/SW
alloc_pd  in  1  predicted jump (`Jump/`NotJump)
alloc_nick  out  NICK_W  nick to be assigned (combinational = tail)
full  out  1  combinational, count==DEPTH
ex_en  in  1  EX result valid
ex_nick  in  NICK_W  producing nick
ex_dt  in  DATA_W  result
ex_ac  in  1  actual jump outcome
ex_j_pc  in  DATA_W  correct target PC
slb_en  in  1  SLB result valid (load data, or store address-ready)
slb_nick  in  NICK_W  nick
slb_dt  in  DATA_W  load data
store_en  out  1  head store may write memory
store_nick  out  NICK_W  nick of that store
store_ack  in  1  SLB has performed the store
rf_en  out  COMMIT_W  per-slot regfile write
rf_regnm  out  5*COMMIT_W  per-slot register name
rf_dt  out  DATA_W*COMMIT_W  per-slot data
rf_nick  out  NICK_W*COMMIT_W  per-slot nick (regfile clears rename if it still matches)
clr  out  1  one-cycle flush pulse
j_pc  out  DATA_W  redirect PC, valid with clr

Behaviour:
- Reset (sync): head=tail=1, count=0, every entry's valid/done/store bits cleared. All outputs 0 except alloc_nick=1.
- Pointers wrap DEPTH→1; 0 is never used. count is NICK_W+1 bits.
- Allocate: on the edge with rdy && alloc_en && !full && !clr, write entry[tail], set valid, and advance tail. Allocating while full is ignored. Retirement in the same cycle does not bypass full.
- Writeback: ex_en/slb_en set done and store data/ac/j_pc at the edge. Writeback to an invalid nick is ignored. If ex and slb target the same nick, ex wins. A write landing on edge N is eligible for commit evaluation from cycle N+1.
- Slot 0 (head) retires when valid && done:
  - Plain entry: rf_en[0]=1 with regnm/dt/nick registered, then free the entry.
  - Mispredict (pd≠ac): rf_en[0]=1 (link write), clr=1, j_pc=entry j_pc. On the same edge, every entry is invalidated, head=tail=1, count=0.
  - Store: see store handshake.
- Slot 1 (COMMIT_W=2) retires on the same edge only if slot 0 retired as a plain entry and head+1 is valid, done, not a store, and not mispredicted.
- Store handshake:
  - The head store with done raises store_en/store_nick (registered) and holds them until store_ack.
  - The edge with store_ack && store_en frees the entry. store_en drops the next cycle. No other retirement occurs in that cycle.
  - store_ack without store_en is ignored.
- Outputs: rf_en, clr and store_en are registered. rf_en and clr are single-cycle pulses, 0 when nothing retires.
- Simultaneous allocate and retire: count = count + 1 − retired.
- rdy low: no pointer or entry change. rf_en=0 and clr=0. store_en holds its value.
- rst mid-flush or mid-store: reset dominates; store_en→0.
- A name-0 destination still retires, with rf_en=0 for that slot.

Decomposition:
- Add NickBus, DataBus, NameBus, `Jump/`NotJump and `Store to the shared config header.
- Natural sub-module: rob_commit_sel, combinational. It takes the head/head+1 entry flags and produces the per-slot retire, mispredict and store-issue decisions.

Test Plan:
1. DEPTH=4: allocate 4 entries → full=1, alloc_nick 1,2,3,4. A 5th alloc_en is ignored. After the head retires, alloc_nick=1 (wrap) is granted.
2. Allocate nicks 1,2 (x5, x6); ex writeback 2 then 1 → one cycle with rf_en=2'b11, regnm {6,5}, nicks {2,1}, data correct.
3. Nick 1 is a branch with pd=0, ex_ac=1, j_pc=0x100; nicks 2,3 are done → clr=1 and j_pc=0x100 for exactly 1 cycle, rf_en[1]=0. Next cycle count=0 and alloc_nick=1.
4. The head is a done store → store_en=1, store_nick=1, held 3 cycles without ack. Ack → entry freed, store_en=0 the next cycle, and a done plain entry behind it retires one cycle later.
5. rdy=0 for 2 cycles while the head is done → rf_en stays 0 and count is unchanged. rdy=1 → retirement occurs.
6. rst asserted during store_en=1 with 3 valid entries → next cycle store_en=0, full=0, alloc_nick=1.
